// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Per-bit push-button conditioner. Each bit passes through a
//            two-flop synchroniser and a stability counter, then provides a
//            clean level and single-cycle rise/fall pulses.
// Options  : BTN_DEBOUNCE_TOGGLE_EN - when defined, stable_o carries a
//            per-bit toggle latch that flips on every debounced press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btns_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Terminal count: a differing input is accepted on the edge where the
  // counter already holds this value, so the counter never exceeds it.
  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1_q, sync1_d;
  logic [WIDTH-1:0]     sync2_q, sync2_d;
  logic [WIDTH-1:0]     level_q, level_d;
  logic [WIDTH-1:0]     rise_q,  rise_d;
  logic [WIDTH-1:0]     fall_q,  fall_d;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

  // Next-state: straight synchroniser chain plus independent per-bit filter.
  always_comb begin
    sync1_d = btns_i;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        // Input agrees with the accepted level: any bounce streak is over.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == C_CNT_LAST) begin
        // Input has differed long enough: accept it and emit one pulse.
        cnt_d[i]   = '0;
        level_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // State registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef BTN_DEBOUNCE_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Each accepted press flips the latch on the same edge rise_o is set.
  always_comb begin
    toggle_d = toggle_q ^ rise_d;
  end

  // Toggle latch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign stable_o = toggle_q;
`else
  assign stable_o = level_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_debounce
// Purpose  : Self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4 main
//            instance, DEBOUNCE_CYCLES=1 boundary instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btns;
  logic [3:0] stable, rise, fall;
  logic       btn1;
  logic       stable1, rise1, fall1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] btns;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] tog = 4'b0000;

  always #5 clk = ~clk;

  btn_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btns_i   (btns),
    .stable_o (stable),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  btn_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .btns_i   (btn1),
    .stable_o (stable1),
    .rise_o   (rise1),
    .fall_o   (fall1)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected stable value is the level, or the press-toggled latch.
  function automatic void add(input logic [3:0] b, input logic [3:0] lvl,
                              input logic [3:0] r, input logic [3:0] f);
    vec_t v;
    tog    = tog ^ r;
    v.btns = b;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    v.st   = tog;
`else
    v.st   = lvl;
`endif
    v.ri   = r;
    v.fa   = f;
    vecs.push_back(v);
  endfunction

  // Step to mask and hold n cycles: accepted at the sixth edge (index 5).
  function automatic void press(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++)
      add(mask, (i >= 5) ? mask : 4'b0000, (i == 5) ? mask : 4'b0000, 4'b0000);
  endfunction

  function automatic void release_btn(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++)
      add(4'b0000, (i >= 5) ? 4'b0000 : mask, 4'b0000, (i == 5) ? mask : 4'b0000);
  endfunction

  initial begin
    logic [3:0] bounce_pat [11];
    logic [3:0] exp_rel1;

    rst_n = 1'b0;
    btns  = 4'b0000;
    btn1  = 1'b0;

    // ---------------- table construction ----------------
    tog = 4'b0000;
    press(4'b0001, 20);
    release_btn(4'b0001, 10);
    bounce_pat = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100,
                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 11; i++) add(bounce_pat[i], 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++)  add(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Bounce then settle on bit 1: final low->high step at index 4.
    for (int i = 0; i < 14; i++)
      add((i == 3) ? 4'b0000 : 4'b0010, (i >= 9) ? 4'b0010 : 4'b0000,
          (i == 9) ? 4'b0010 : 4'b0000, 4'b0000);
    release_btn(4'b0010, 10);
    press(4'b1010, 10);
    release_btn(4'b1010, 10);
    for (int p = 0; p < 3; p++) begin
      press(4'b1000, 8);
      release_btn(4'b1000, 8);
    end

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset_stable", stable, 4'b0000);
    check("reset_rise",   rise,   4'b0000);
    check("reset_fall",   fall,   4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- asynchronous reset with buttons held ----------------
    tick;
    btns = 4'b1111;
    repeat (8) tick;
    check("pre_reset_stable", stable, 4'b1111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stable", stable, 4'b0000);
    check("async_rst_rise",   rise,   4'b0000);
    check("async_rst_fall",   fall,   4'b0000);
    tick;
    check("held_rst_stable", stable, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick;
      if (e == 5) begin
        check("rst_rel_e5_stable", stable, 4'b0000);
        check("rst_rel_e5_rise",   rise,   4'b0000);
      end
      if (e == 6) begin
        check("rst_rel_e6_stable", stable, 4'b1111);
        check("rst_rel_e6_rise",   rise,   4'b1111);
      end
      if (e == 7) begin
        check("rst_rel_e7_stable", stable, 4'b1111);
        check("rst_rel_e7_rise",   rise,   4'b0000);
      end
    end

    // Clean restart for the table phase.
    btns = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      btns = vecs[i].btns;
      tick;
      check($sformatf("vec%0d_stable", i), stable, vecs[i].st);
      check($sformatf("vec%0d_rise",   i), rise,   vecs[i].ri);
      check($sformatf("vec%0d_fall",   i), fall,   vecs[i].fa);
    end

    // ---------------- DEBOUNCE_CYCLES = 1 boundary ----------------
    btn1 = 1'b1;
    tick;
    tick;
    check("d1_press_e2_stable", {3'b000, stable1}, 4'b0000);
    tick;
    check("d1_press_e3_stable", {3'b000, stable1}, 4'b0001);
    check("d1_press_e3_rise",   {3'b000, rise1},   4'b0001);
    tick;
    check("d1_press_e4_rise",   {3'b000, rise1},   4'b0000);
    btn1 = 1'b0;
    tick;
    tick;
    check("d1_rel_e2_fall", {3'b000, fall1}, 4'b0000);
    tick;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    exp_rel1 = 4'b0001;
`else
    exp_rel1 = 4'b0000;
`endif
    check("d1_rel_e3_stable", {3'b000, stable1}, exp_rel1);
    check("d1_rel_e3_fall",   {3'b000, fall1},   4'b0001);
    check("d1_rel_e3_rise",   {3'b000, rise1},   4'b0000);
    tick;
    check("d1_rel_e4_fall", {3'b000, fall1}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
